// File: rtl/aer_pkg.sv
// Shared AER word definitions used by the event FIFO and its neighbours.
package aer_pkg;

  localparam int AER_WORD_W     = 24;
  localparam int AER_FIFO_DEPTH = 16;

  typedef logic [AER_WORD_W-1:0] aer_word_t;

endpackage

// File: rtl/aer_fifo_if.sv
// Write/read handshake, status and error bundle for the AER event FIFO.
interface aer_fifo_if #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, din, rd_en,
    input  dout, full, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, full, empty, count, overflow, underflow
  );

endinterface

// File: rtl/aer_fifo_mem.sv
// Dual-port register array: synchronous write, registered synchronous read.
module aer_fifo_mem #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A same-address write in this cycle is not visible here: read returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/aer_fifo.sv
// Single-clock FIFO for AER event words with registered read data,
// occupancy count and sticky overflow/underflow flags.
module aer_fifo
  import aer_pkg::*;
#(
  parameter int DATA_W = AER_WORD_W,
  parameter int DEPTH  = AER_FIFO_DEPTH
) (
  input logic       clk,
  input logic       rst,
  aer_fifo_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              full;
  logic              empty;
  logic              rd_acc;
  logic              wr_acc;

  // Flags come only from the registered count, so no input reaches them combinationally.
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

  // A read frees a slot in the same cycle, so a full FIFO still takes a paired write.
  assign rd_acc = bus.rd_en & ~empty;
  assign wr_acc = bus.wr_en & (~full | rd_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_acc && !rd_acc) begin
        count_q <= count_q + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count_q <= count_q - 1'b1;
      end
      overflow_q  <= overflow_q  | (bus.wr_en & ~wr_acc);
      underflow_q <= underflow_q | (bus.rd_en & ~rd_acc);
    end
  end

  aer_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr),
    .wdata (bus.din),
    .re    (rd_acc & ~rst),
    .raddr (rd_ptr),
    .rdata (bus.dout)
  );

  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_aer_fifo.sv
// Scoreboard bench for aer_fifo: a queue model predicts read data, count and flags.
module tb_aer_fifo;
  import aer_pkg::*;

  localparam int DEPTH = AER_FIFO_DEPTH;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  aer_fifo_if #(.DATA_W(AER_WORD_W), .DEPTH(DEPTH)) bus ();

  aer_fifo #(.DATA_W(AER_WORD_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  aer_word_t sb_q[$];
  aer_word_t m_dout;
  aer_word_t rd_exp;
  bit        m_ovf;
  bit        m_unf;
  bit        rd_hit;
  int        checks = 0;
  int        errors = 0;

  // Apply one cycle of stimulus, advance the model, and leave outputs settled for sampling.
  task automatic drive(input bit wr, input aer_word_t d, input bit rd, input bit r = 1'b0);
    bit rd_ok;
    bit wr_ok;
    rst       = r;
    bus.wr_en = wr;
    bus.din   = d;
    bus.rd_en = rd;
    @(posedge clk);
    rd_hit = 1'b0;
    if (r) begin
      sb_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      rd_ok = rd && (sb_q.size() > 0);
      wr_ok = wr && ((sb_q.size() < DEPTH) || rd_ok);
      if (rd_ok) begin
        rd_exp = sb_q.pop_front();
        m_dout = rd_exp;
        rd_hit = 1'b1;
      end
      if (wr_ok) sb_q.push_back(d);
      if (wr && !wr_ok) m_ovf = 1'b1;
      if (rd && !rd_ok) m_unf = 1'b1;
    end
    #1;
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 24'hFFFFFF, 1'b0, 1'b1);
    drive(1'b1, 24'hEEEEEE, 1'b0, 1'b1);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    checks++; if (bus.dout !== 24'h000000) begin errors++; $display("FAIL reset_dout got %h exp 000000", bus.dout); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", bus.overflow); end
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b exp 0", bus.underflow); end
  endtask

  task automatic test_fill_drain();
    aer_word_t v;
    for (int i = 0; i < DEPTH; i++) begin
      v = 24'(i * 24'h0000F1);
      drive(1'b1, v, 1'b0);
    end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", bus.full); end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d exp 16", bus.count); end
    for (int i = 0; i < DEPTH; i++) begin
      v = 24'(i * 24'h0000F1);
      drive(1'b0, '0, 1'b1);
      checks++;
      if (!rd_hit || bus.dout !== v) begin
        errors++; $display("FAIL drain_order[%0d] got %h exp %h", i, bus.dout, v);
      end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", bus.empty); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 24'h300000 + 24'(i), 1'b0);
    drive(1'b1, 24'hABCDEF, 1'b0);
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", bus.count); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", bus.overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1);
      checks++;
      if (!rd_hit || bus.dout !== rd_exp || bus.dout === 24'hABCDEF) begin
        errors++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, bus.dout, rd_exp);
      end
    end
  endtask

  task automatic test_underflow();
    aer_word_t held;
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 24'h0BEEF0, 1'b0);
    drive(1'b0, '0, 1'b1);
    held = m_dout;
    drive(1'b0, '0, 1'b1);
    checks++; if (bus.dout !== held) begin errors++; $display("FAIL unf_dout got %h exp %h", bus.dout, held); end
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL unf_flag got %b exp 1", bus.underflow); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL unf_count got %0d exp 0", bus.count); end
    checks++; if (bus.overflow !== m_ovf) begin errors++; $display("FAIL unf_ovf got %b exp %b", bus.overflow, m_ovf); end
  endtask

  task automatic test_simultaneous_full();
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 24'h000100 + 24'(i), 1'b0);
    drive(1'b1, 24'h123456, 1'b1);
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL simf_count got %0d exp 16", bus.count); end
    checks++; if (bus.dout !== 24'h000100) begin errors++; $display("FAIL simf_dout got %h exp 000100", bus.dout); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL simf_ovf got %b exp 0", bus.overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1);
      checks++;
      if (!rd_hit || bus.dout !== rd_exp) begin
        errors++; $display("FAIL simf_drain[%0d] got %h exp %h", i, bus.dout, rd_exp);
      end
    end
    checks++; if (bus.dout !== 24'h123456) begin errors++; $display("FAIL simf_last got %h exp 123456", bus.dout); end
  endtask

  task automatic test_simultaneous_empty();
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 24'h777777, 1'b1);
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL sime_count got %0d exp 1", bus.count); end
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL sime_unf got %b exp 1", bus.underflow); end
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL sime_empty got %b exp 0", bus.empty); end
    checks++; if (bus.dout !== 24'h000000) begin errors++; $display("FAIL sime_dout got %h exp 000000", bus.dout); end
    drive(1'b0, '0, 1'b1);
    checks++; if (bus.dout !== 24'h777777) begin errors++; $display("FAIL sime_read got %h exp 777777", bus.dout); end
  endtask

  task automatic test_wrap();
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 24'hA00000 + 24'(i), (i % 3) != 0);
      if (rd_hit) begin
        checks++;
        if (bus.dout !== rd_exp) begin errors++; $display("FAIL wrap_order[%0d] got %h exp %h", i, bus.dout, rd_exp); end
      end
    end
    checks++; if (bus.count !== 5'(sb_q.size())) begin errors++; $display("FAIL wrap_count got %0d exp %0d", bus.count, sb_q.size()); end
    for (int guard = 0; guard < 2 * DEPTH && sb_q.size() > 0; guard++) begin
      drive(1'b0, '0, 1'b1);
      checks++;
      if (bus.dout !== rd_exp) begin errors++; $display("FAIL wrap_drain[%0d] got %h exp %h", guard, bus.dout, rd_exp); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", bus.empty); end
    checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++; $display("FAIL wrap_errflags got %b%b exp 00", bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 24'hC00000 + 24'(i), 1'b0);
    checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL mrst_pre_count got %0d exp 5", bus.count); end
    drive(1'b1, 24'hDDDDDD, 1'b1, 1'b1);
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL mrst_count got %0d exp 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL mrst_empty got %b exp 1", bus.empty); end
    checks++; if (bus.dout !== 24'h000000) begin errors++; $display("FAIL mrst_dout got %h exp 000000", bus.dout); end
    drive(1'b1, 24'h5A5A5A, 1'b0);
    drive(1'b0, '0, 1'b1);
    checks++; if (bus.dout !== 24'h5A5A5A) begin errors++; $display("FAIL mrst_read got %h exp 5A5A5A", bus.dout); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL mrst_final_empty got %b exp 1", bus.empty); end
  endtask

  initial begin
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = '0;
    m_dout    = '0;
    rd_exp    = '0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
    rd_hit    = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_simultaneous_full();
    test_simultaneous_empty();
    test_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
